add64_bus_loader: RTL and testbench

ADD64_BUS_LOADER -- requirements
Module: add64_bus_loader

---
 rtl/add64_bus_loader_pkg.sv | 15 +
 rtl/add64_bus_loader_rca.sv | 31 +++
 rtl/add64_bus_loader.sv | 141 ++++++++++++++
 tb/tb_add64_bus_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add64_bus_loader_pkg.sv
// add64_bus_loader_pkg
// Shared constants and a small helper for the 64-bit bus-loaded adder.
//   OpWidth  : operand and sum width in bits
//   BusWidth : width of one bus beat
//   beat_base: bit offset of the 16-bit slice selected by a 2-bit beat index
package add64_bus_loader_pkg;

    localparam int unsigned OpWidth  = 64;
    localparam int unsigned BusWidth = 16;

    function automatic logic [5:0] beat_base(input logic [1:0] beat);
        return {beat, 4'b0000};
    endfunction

endpackage

// File: rtl/add64_bus_loader_rca.sv
// add64_bus_loader_rca
// 64-bit ripple-carry adder: {c_out, sum} = a + b + c_in.
// Ports (fixed order):
//   c_out : carry out of bit 63
//   sum   : 64-bit wrapped sum
//   a, b  : operands
//   c_in  : carry into bit 0
module add64_bus_loader_rca
    import add64_bus_loader_pkg::*;
(
    output logic               c_out,
    output logic [OpWidth-1:0] sum,
    input  logic [OpWidth-1:0] a,
    input  logic [OpWidth-1:0] b,
    input  logic               c_in
);

    logic [OpWidth:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < OpWidth; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[OpWidth];
    end

endmodule

// File: rtl/add64_bus_loader.sv
// add64_bus_loader
// Loads two 64-bit operands as four 16-bit beats each (A then B, LSB word
// first), adds them with a carry-in in one cycle, then streams the sum back
// out as four 16-bit beats with carry-out on the last beat.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_data word, in_cin on A beat 0
//   out_valid/out_ready : result handshake; out_data word, out_last on beat 3,
//                         out_cout carry-out (beat 3 only)
//   busy                : a transaction is partially loaded, computing or sending
module add64_bus_loader
    import add64_bus_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BusWidth-1:0] in_data,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BusWidth-1:0] out_data,
    output logic                out_last,
    output logic                out_cout,
    output logic                busy
);

    typedef enum logic [1:0] {
        StLoadA = 2'd0,
        StLoadB = 2'd1,
        StAdd   = 2'd2,
        StSend  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [OpWidth-1:0]   a_q, a_d;
    logic [OpWidth-1:0]   b_q, b_d;
    logic [OpWidth-1:0]   s_q, s_d;
    logic                 cin_q, cin_d;
    logic                 cout_q, cout_d;

    logic [OpWidth-1:0]   add_sum;
    logic                 add_cout;

    add64_bus_loader_rca u_rca (
        .c_out (add_cout),
        .sum   (add_sum),
        .a     (a_q),
        .b     (b_q),
        .c_in  (cin_q)
    );

    // Handshake outputs depend only on state_q/beat_q, never on in_valid/out_ready.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        cin_d     = cin_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_cout  = 1'b0;

        unique case (state_q)
            StLoadA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d[beat_base(beat_q) +: BusWidth] = in_data;
                    if (beat_q == 2'd0) begin
                        cin_d = in_cin;
                    end
                    // Counter wraps 3 -> 0, ready for B beat 0.
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StLoadB;
                    end
                end
            end
            StLoadB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d[beat_base(beat_q) +: BusWidth] = in_data;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StAdd;
                    end
                end
            end
            StAdd: begin
                s_d     = add_sum;
                cout_d  = add_cout;
                beat_d  = 2'd0;
                state_d = StSend;
            end
            StSend: begin
                out_valid = 1'b1;
                out_data  = s_q[beat_base(beat_q) +: BusWidth];
                out_last  = (beat_q == 2'd3);
                out_cout  = (beat_q == 2'd3) ? cout_q : 1'b0;
                if (out_ready) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StLoadA;
                    end
                end
            end
            default: begin
                state_d = StLoadA;
                beat_d  = 2'd0;
            end
        endcase
    end

    assign busy = !((state_q == StLoadA) && (beat_q == 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoadA;
            beat_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cin_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cin_q   <= cin_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_add64_bus_loader.sv
// tb_add64_bus_loader
// Scoreboard bench: each issued transaction pushes its four expected sum beats
// (from plain 65-bit arithmetic) into a queue; a monitor compares every
// presented output beat against the queue head and pops on transfer.
module tb_add64_bus_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_cout;
    logic        busy;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        cout;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          checks   = 0;
    int          failures = 0;
    bit          auto_ready = 1'b1;
    int unsigned ready_pct  = 100;

    always #5 clk = ~clk;

    add64_bus_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Reference model: sum of two 64-bit values plus carry, as 65-bit arithmetic.
    task automatic push_expected(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] full;
        logic [63:0] s;
        beat_t       e;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        s    = full[63:0];
        for (int k = 0; k < 4; k++) begin
            e.data = s[16*k +: 16];
            e.last = (k == 3);
            e.cout = (k == 3) ? full[64] : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // mode 0: back-to-back, 1: random idle gaps, 2: idle every other cycle
    task automatic send_beat(input logic [15:0] d, input logic c, input int mode);
        int n;
        if (mode != 0) begin
            in_valid = 1'b0;
            n = (mode == 2) ? 1 : int'($urandom_range(2));
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                timeout_fail("in_ready_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_txn(input logic [63:0] a, input logic [63:0] b, input logic cin,
                            input int mode, input bit hold);
        int n;
        push_expected(a, b, cin);
        for (int k = 0; k < 4; k++) begin
            send_beat(a[16*k +: 16], (k == 0) ? cin : 1'($urandom), mode);
        end
        for (int k = 0; k < 4; k++) begin
            send_beat(b[16*k +: 16], 1'($urandom), mode);
        end
        if (hold) begin
            // Junk held valid across ADD/SEND must be ignored.
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_cin   = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        check("in_ready_add", 64'(in_ready), 64'd0);
        check("out_valid_add", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("out_valid_latency", 64'(out_valid), 64'd1);
        check("in_ready_send", 64'(in_ready), 64'd0);
        if (hold) begin
            n = 0;
            while (!(out_valid && out_last && out_ready)) begin
                @(negedge clk);
                n++;
                if (n > 300) begin
                    timeout_fail("hold_last_wait");
                    break;
                end
            end
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_out_cout"}, 64'(out_cout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Background out_ready driver; main flow takes over when auto_ready is cleared.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ready) out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: compare each presented beat with the scoreboard head; pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_out_beat");
                    end else begin
                        mon_e = exp_q[0];
                        check("out_data", 64'(out_data), 64'(mon_e.data));
                        check("out_last", 64'(out_last), 64'(mon_e.last));
                        check("out_cout", 64'(out_cout), 64'(mon_e.cout));
                        check("in_ready_in_send", 64'(in_ready), 64'd0);
                        check("busy_in_send", 64'(busy), 64'd1);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    check("out_cout_idle", 64'(out_cout), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_cin   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sums
        send_txn(64'h0123456789ABCDEF, 64'h1111111111111111, 1'b1, 0, 1'b0);
        send_txn(64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 1'b0);
        send_txn(64'h000000000000FFFF, 64'h0000000000000001, 1'b0, 0, 1'b0);
        drain();

        // Output stall of three cycles on beat 1
        auto_ready = 1'b0;
        out_ready  = 1'b1;
        send_txn(64'h0123456789ABCDEF, 64'h1111111111111111, 1'b1, 0, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_data", 64'(out_data), 64'h9ABC);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        auto_ready = 1'b1;

        // Alternating in_valid, junk held valid during ADD/SEND
        send_txn(64'h0123456789ABCDEF, 64'h1111111111111111, 1'b1, 2, 1'b1);
        drain();

        // Reset after two A beats
        send_beat(16'hAAAA, 1'b1, 0);
        send_beat(16'h5555, 1'b0, 0);
        in_valid = 1'b0;
        check("busy_partial", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_txn(64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 1'b0);
        drain();

        // Randomized traffic with output backpressure
        ready_pct = 70;
        for (int i = 0; i < 20; i++) begin
            ra = {32'($urandom), 32'($urandom)};
            rb = {32'($urandom), 32'($urandom)};
            if (i % 5 == 1) rb = ~ra;
            if (i % 7 == 3) ra = 64'hFFFFFFFFFFFFFFFF;
            send_txn(ra, rb, 1'($urandom), 1, (i % 4) == 0);
        end
        ready_pct = 100;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
